// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small byte FIFO in front of it.
// Bytes written on tx_din/tx_wen are queued, then serialized onto tx as
// 8N1 frames (start, 8 data bits LSB first, stop). Frames leave back to
// back while the FIFO still holds data.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 900,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic [7:0]       tx_din,
  input  logic             tx_wen,
  output logic             tx_full,
  output logic             tx_empty,
  output logic [CNT_W-1:0] tx_count,
  output logic             tx_busy,
  output logic             tx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_s;
  logic             full_r;
  logic             empty_r;
  logic             push_s;
  logic             pop_s;

  // Serializer state
  state_t           state_r;
  state_t           state_s;
  logic [BAUD_W-1:0] baud_r;
  logic [BAUD_W-1:0] baud_s;
  logic [2:0]       bit_idx_r;
  logic [2:0]       bit_idx_s;
  logic [7:0]       shift_r;
  logic [7:0]       shift_s;
  logic             tx_r;
  logic             tx_s;
  logic             busy_r;
  logic             baud_done_s;

  // A full FIFO drops the write outright, even when a pop frees a slot on the same edge.
  assign push_s      = tx_wen & ~full_r;
  assign baud_done_s = (baud_r == BAUD_LAST);

  // Next occupancy from the push/pop pair; pops only happen when not empty.
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_W'(1);
      2'b01:   count_s = count_r - CNT_W'(1);
      default: count_s = count_r;
    endcase
  end

  // FIFO pointers and registered status flags.
  always_ff @(posedge clk) begin
    if (Rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_s;
      full_r  <= (count_s == CNT_FULL);
      empty_r <= (count_s == CNT_W'(0));
    end
  end

  // FIFO data array; contents need no reset because the pointers discard them.
  always_ff @(posedge clk) begin
    if (push_s && !Rst) begin
      mem_r[wr_ptr_r] <= tx_din;
    end
  end

  // Next-state, baud/bit counters, shift register and line level for the serializer.
  always_comb begin
    state_s   = state_r;
    baud_s    = baud_r + BAUD_W'(1);
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    tx_s      = tx_r;
    pop_s     = 1'b0;
    case (state_r)
      IDLE: begin
        baud_s = '0;
        if (!empty_r) begin
          pop_s     = 1'b1;
          shift_s   = mem_r[rd_ptr_r];
          bit_idx_s = 3'd0;
          state_s   = START;
          tx_s      = 1'b0;
        end else begin
          state_s = IDLE;
          tx_s    = 1'b1;
        end
      end
      START: begin
        if (baud_done_s) begin
          baud_s    = '0;
          bit_idx_s = 3'd0;
          state_s   = DATA;
          tx_s      = shift_r[0];
        end else begin
          tx_s = 1'b0;
        end
      end
      DATA: begin
        if (baud_done_s) begin
          baud_s = '0;
          if (bit_idx_r == 3'd7) begin
            state_s = STOP;
            tx_s    = 1'b1;
          end else begin
            shift_s   = {1'b0, shift_r[7:1]};
            bit_idx_s = bit_idx_r + 3'd1;
            tx_s      = shift_r[1];
          end
        end else begin
          tx_s = shift_r[0];
        end
      end
      STOP: begin
        if (baud_done_s) begin
          baud_s = '0;
          if (!empty_r) begin
            // Chain straight into the next frame with no idle gap.
            pop_s     = 1'b1;
            shift_s   = mem_r[rd_ptr_r];
            bit_idx_s = 3'd0;
            state_s   = START;
            tx_s      = 1'b0;
          end else begin
            state_s = IDLE;
            tx_s    = 1'b1;
          end
        end else begin
          tx_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        baud_s  = '0;
        tx_s    = 1'b1;
      end
    endcase
  end

  // Serializer registers; tx and busy come straight from flops so the line is glitch-free.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_r   <= IDLE;
      baud_r    <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      baud_r    <= baud_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      tx_r      <= tx_s;
      busy_r    <= (state_s != IDLE);
    end
  end

  assign tx       = tx_r;
  assign tx_busy  = busy_r;
  assign tx_full  = full_r;
  assign tx_empty = empty_r;
  assign tx_count = count_r;

endmodule
